// File: rtl/and_chain_pkg.sv
// Shared types and constants for the serial prefix-AND receiver.
// Provides the FSM state type, the default word width and the count-width helper.
package and_chain_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam int AND_CHAIN_W = 4;

  // Bits needed to represent every value 0..w inclusive.
  function automatic int clog2w(input int w);
    int n;
    n = 0;
    while ((1 << n) <= w) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/and_chain_serial_rx.sv
// Bit-serial collector building the prefix-AND vector and leading-ones count of a WIDTH-bit word.
// Result valid one cycle after the last accepted bit; in_ready stays low until the word is taken.
module and_chain_serial_rx
  import and_chain_pkg::*;
#(
  parameter  int WIDTH = AND_CHAIN_W,
  localparam int CNT_W = clog2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-2:0] out_prefix,
  output logic             out_all,
  output logic [CNT_W-1:0] out_ones
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_run;
  logic [WIDTH-2:0] r_prefix;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-2:0] r_out_prefix;
  logic             r_out_all;
  logic [CNT_W-1:0] r_out_ones;

  logic             w_acc;
  logic             w_last;
  logic             w_take;
  logic             w_run_new;
  logic [WIDTH-2:0] w_prefix_new;
  logic [CNT_W-1:0] w_ones_new;

  assign w_acc      = in_valid & r_in_ready;
  assign w_last     = w_acc && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_take     = r_out_valid & out_ready;
  // run rests at 1 between words, so the first bit simply loads it
  assign w_run_new  = r_run & in_bit;
  assign w_ones_new = r_ones + CNT_W'(w_run_new);

  always_comb begin
    w_prefix_new = r_prefix;
    for (int k = 0; k < WIDTH - 1; k++) begin
      if (r_cnt == CNT_W'(k + 1)) w_prefix_new[k] = w_run_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_last) begin
            r_state     <= FULL;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_take) begin
            r_state     <= COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= COLLECT;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run        <= 1'b1;
      r_prefix     <= '0;
      r_ones       <= '0;
      r_cnt        <= '0;
      r_out_prefix <= '0;
      r_out_all    <= 1'b0;
      r_out_ones   <= '0;
    end else if (w_take) begin
      r_run    <= 1'b1;
      r_prefix <= '0;
      r_ones   <= '0;
      r_cnt    <= '0;
    end else if (w_acc) begin
      r_run    <= w_run_new;
      r_prefix <= w_prefix_new;
      r_ones   <= w_ones_new;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_prefix <= w_prefix_new;
        r_out_all    <= w_prefix_new[WIDTH-2];
        r_out_ones   <= w_ones_new;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_prefix = r_out_prefix;
  assign out_all    = r_out_all;
  assign out_ones   = r_out_ones;

endmodule
